dual_port_ram: RTL and testbench

- Parameterised simple dual-port RAM: one write port, one read port, single clock.
- Used as per-entry metadata storage, e.g. the instruction-fetch stage stores {PC, tmask} indexed by warp id when a request is issued.
- The stage reads the entry back by response tag in the same cycle the response is consumed.
- Supports optional byte-enable writes and optional registered read output.

---
 rtl/dual_port_ram_if.sv | 24 ++
 rtl/dual_port_ram.sv | 82 ++++++++
 tb/tb_dual_port_ram.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_if.sv
// rtl/dual_port_ram_if.sv - write/read port bundle for dual_port_ram
interface dual_port_ram_if #(
    parameter int DATAW   = 1,
    parameter int ADDRW   = 1,
    parameter int BYTEENW = 1
);
    logic               wren;
    logic [ADDRW-1:0]   waddr;
    logic [BYTEENW-1:0] byteen;
    logic [DATAW-1:0]   din;
    logic               rden;
    logic [ADDRW-1:0]   raddr;
    logic [DATAW-1:0]   dout;

    modport master (
        output wren, waddr, byteen, din, rden, raddr,
        input  dout
    );

    modport slave (
        input  wren, waddr, byteen, din, rden, raddr,
        output dout
    );
endinterface

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - simple dual-port RAM, one write port, one read port, single clock
module dual_port_ram #(
    parameter int DATAW    = 1,
    parameter int SIZE     = 1,
    parameter int BYTEENW  = 1,
    parameter int BUFFERED = 0,
    parameter int FASTRAM  = 0,
    parameter int INITZERO = 0
) (
    input  logic            clk,
    input  logic            reset,
    dual_port_ram_if.slave  bus
);
    localparam int ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1;

    // Parameter sanity; FASTRAM is only a storage-style hint and INITZERO a power-up flag.
    if (SIZE < 1) begin : g_chk_size
        $fatal(1, "dual_port_ram: SIZE must be >= 1");
    end
    if (BYTEENW != 1 && BYTEENW != DATAW / 8) begin : g_chk_byteen
        $fatal(1, "dual_port_ram: BYTEENW must be 1 or DATAW/8");
    end
    if (BYTEENW > 1 && (DATAW % 8) != 0) begin : g_chk_dataw
        $fatal(1, "dual_port_ram: byte enables need DATAW to be a multiple of 8");
    end
    if (FASTRAM < 0 || FASTRAM > 1 || INITZERO < 0 || INITZERO > 1) begin : g_chk_flags
        $fatal(1, "dual_port_ram: FASTRAM and INITZERO must be 0 or 1");
    end
    if ($bits(bus.waddr) != ADDRW || $bits(bus.din) != DATAW || $bits(bus.byteen) != BYTEENW) begin : g_chk_if
        $fatal(1, "dual_port_ram: interface widths do not match RAM parameters");
    end

    // Zero at power-up is a legal value for "undefined" too, so one init serves both INITZERO settings.
    logic [DATAW-1:0] mem [SIZE] = '{default: '0};

    logic [DATAW-1:0] wmask;
    logic [DATAW-1:0] rdata;
    logic             waddr_ok;
    logic             raddr_ok;

    // Expand byte enables to a per-bit write mask.
    if (BYTEENW == 1) begin : g_mask_word
        assign wmask = {DATAW{bus.byteen[0]}};
    end else begin : g_mask_bytes
        for (genvar i = 0; i < BYTEENW; i++) begin : g_byte
            assign wmask[8*i +: 8] = {8{bus.byteen[i]}};
        end
    end

    assign waddr_ok = (32'(bus.waddr) < SIZE);
    assign raddr_ok = (32'(bus.raddr) < SIZE);

    // Masked write; out-of-range addresses are dropped and reset never gates writes.
    always_ff @(posedge clk) begin
        if (bus.wren && waddr_ok) begin
            mem[bus.waddr] <= (mem[bus.waddr] & ~wmask) | (bus.din & wmask);
        end
    end

    assign rdata = raddr_ok ? mem[bus.raddr] : '0;

    if (BUFFERED != 0) begin : g_rd_reg
        logic [DATAW-1:0] dout_q;

        // Registered read samples the array before this edge's write lands (read-first).
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q <= '0;
            end else if (bus.rden) begin
                dout_q <= rdata;
            end
        end

        assign bus.dout = dout_q;
    end else begin : g_rd_async
        logic unused_ok;

        assign bus.dout  = rdata;
        // Combinational read ignores rden and reset.
        assign unused_ok = ^{reset, bus.rden};
    end
endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - randomized and directed checks of dual_port_ram against a behavioural model
module tb_dual_port_ram;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    dual_port_ram_if #(.DATAW(36), .ADDRW(2), .BYTEENW(1)) bus_a ();
    dual_port_ram_if #(.DATAW(32), .ADDRW(3), .BYTEENW(4)) bus_b ();
    dual_port_ram_if #(.DATAW(32), .ADDRW(3), .BYTEENW(4)) bus_c ();

    // A: 36-bit async word RAM; B: registered byte-enable RAM; C: async twin of B on the same inputs
    dual_port_ram #(.DATAW(36), .SIZE(4), .BYTEENW(1), .BUFFERED(0), .FASTRAM(1), .INITZERO(0))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    dual_port_ram #(.DATAW(32), .SIZE(5), .BYTEENW(4), .BUFFERED(1), .FASTRAM(0), .INITZERO(1))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
    dual_port_ram #(.DATAW(32), .SIZE(5), .BYTEENW(4), .BUFFERED(0), .FASTRAM(0), .INITZERO(1))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

    assign bus_c.wren   = bus_b.wren;
    assign bus_c.waddr  = bus_b.waddr;
    assign bus_c.byteen = bus_b.byteen;
    assign bus_c.din    = bus_b.din;
    assign bus_c.rden   = bus_b.rden;
    assign bus_c.raddr  = bus_b.raddr;

    // Behavioural model state
    logic [35:0] mem_a [4];
    bit          val_a [4];
    logic [31:0] mem_b [5];
    logic [31:0] exp_b;

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = '0;
            val_a[i] = 1'b0;
        end
        for (int i = 0; i < 5; i++) mem_b[i] = '0;
        exp_b = '0;
    end

    function automatic logic [31:0] model_rd_b(input logic [2:0] a);
        return (a < 3'd5) ? mem_b[a] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge: registered read takes the pre-write contents.
    always @(posedge clk) begin
        if (bus_a.wren && bus_a.byteen[0]) begin
            mem_a[bus_a.waddr] = bus_a.din;
            val_a[bus_a.waddr] = 1'b1;
        end
        if (reset) exp_b = '0;
        else if (bus_b.rden) exp_b = model_rd_b(bus_b.raddr);
        if (bus_b.wren && bus_b.waddr < 3'd5) begin
            for (int i = 0; i < 4; i++)
                if (bus_b.byteen[i]) mem_b[bus_b.waddr][8*i +: 8] = bus_b.din[8*i +: 8];
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (val_a[bus_a.raddr]) check("model_a", 64'(bus_a.dout), 64'(mem_a[bus_a.raddr]));
            check("model_b", 64'(bus_b.dout), 64'(exp_b));
            check("model_c", 64'(bus_c.dout), 64'(model_rd_b(bus_c.raddr)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input bit we, input logic [2:0] wa, input logic [3:0] be,
                         input logic [31:0] d, input bit re, input logic [2:0] ra);
        bus_b.wren = we; bus_b.waddr = wa; bus_b.byteen = be;
        bus_b.din = d; bus_b.rden = re; bus_b.raddr = ra;
    endtask

    initial begin
        bus_a.wren = 0; bus_a.waddr = 0; bus_a.byteen = 1'b1; bus_a.din = 0;
        bus_a.rden = 0; bus_a.raddr = 0;
        set_b(0, 0, 0, 0, 0, 0);
        step(); step();
        check("reset_dout_b", 64'(bus_b.dout), 64'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Async 36-bit write/read
        bus_a.wren = 1; bus_a.waddr = 2; bus_a.din = 36'h8_0000_000F; step();
        bus_a.waddr = 1; bus_a.din = 36'h1_2345_6783; step();
        bus_a.wren = 0; bus_a.raddr = 2; #1;
        check("async_rd_a2", 64'(bus_a.dout), 64'h8_0000_000F);
        bus_a.raddr = 1; #1;
        check("async_rd_a1", 64'(bus_a.dout), 64'h1_2345_6783);

        // Async same-cycle read/write
        bus_a.wren = 1; bus_a.waddr = 3; bus_a.din = 36'hA; step();
        bus_a.din = 36'hB; bus_a.raddr = 3; #1;
        check("async_rdw_before", 64'(bus_a.dout), 64'hA);
        step();
        bus_a.wren = 0; #1;
        check("async_rdw_after", 64'(bus_a.dout), 64'hB);

        // Byte enables
        set_b(1, 0, 4'hF, 32'hAABBCCDD, 0, 0); step();
        set_b(1, 0, 4'b0101, 32'h11223344, 0, 0); step();
        set_b(1, 0, 4'b0000, 32'h12345678, 0, 0); step();
        set_b(0, 0, 0, 0, 0, 0); #1;
        check("byteen_c", 64'(bus_c.dout), 64'hAA22CC44);
        set_b(0, 0, 0, 0, 1, 0); step();
        check("byteen_b", 64'(bus_b.dout), 64'hAA22CC44);

        // Registered read: latency, hold, read-first
        set_b(1, 0, 4'hF, 32'h55, 0, 0); step();
        set_b(0, 0, 0, 0, 1, 0); step();
        check("reg_rd", 64'(bus_b.dout), 64'h55);
        set_b(0, 0, 0, 0, 0, 1); step();
        check("reg_hold", 64'(bus_b.dout), 64'h55);
        set_b(1, 0, 4'hF, 32'h66, 1, 0); step();
        check("reg_read_first", 64'(bus_b.dout), 64'h55);
        set_b(0, 0, 0, 0, 1, 0); step();
        check("reg_new_data", 64'(bus_b.dout), 64'h66);

        // Reset clears registered dout only
        set_b(1, 0, 4'hF, 32'h55, 0, 0); step();
        set_b(0, 0, 0, 0, 1, 0); step();
        reset = 1'b1; bus_a.raddr = 1; set_b(0, 0, 0, 0, 0, 0); step();
        check("reset_b", 64'(bus_b.dout), 64'h0);
        check("reset_c_kept", 64'(bus_c.dout), 64'h55);
        check("reset_a_kept", 64'(bus_a.dout), 64'h1_2345_6783);
        reset = 1'b0; set_b(0, 0, 0, 0, 1, 0); step();
        check("mem_after_reset", 64'(bus_b.dout), 64'h55);

        // Non-power-of-two depth
        set_b(1, 6, 4'hF, 32'hFFFFFFFF, 0, 6); step();
        set_b(0, 0, 0, 0, 1, 6); #1;
        check("oor_c", 64'(bus_c.dout), 64'h0);
        step();
        check("oor_b", 64'(bus_b.dout), 64'h0);
        set_b(1, 4, 4'hF, 32'hDEADBEEF, 0, 4); step();
        set_b(0, 0, 0, 0, 1, 4); step();
        check("top_c", 64'(bus_c.dout), 64'hDEADBEEF);
        check("top_b", 64'(bus_b.dout), 64'hDEADBEEF);
        set_b(0, 0, 0, 0, 0, 3); #1;
        check("initzero_c", 64'(bus_c.dout), 64'h0);

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 19) == 0);
            bus_a.wren = 1'($urandom_range(0, 1));
            bus_a.waddr = 2'($urandom_range(0, 3));
            bus_a.byteen = 1'($urandom_range(0, 1));
            bus_a.din = {4'($urandom), 32'($urandom)};
            bus_a.rden = 1'($urandom_range(0, 1));
            bus_a.raddr = 2'($urandom_range(0, 3));
            set_b(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  32'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            step();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
